// File: rtl/axis_uart_tx_if.sv
// Ready/valid byte channel feeding the UART transmitter.
interface axis_uart_tx_if;
    logic [7:0] idata;
    logic       ivalid;
    logic       iready;

    modport master (output idata, output ivalid, input iready);
    modport slave  (input idata, input ivalid, output iready);
endinterface

// File: rtl/axis_uart_tx.sv
// 8N1 UART transmitter draining a ready/valid byte stream, LSB first,
// with back-to-back frames and fully registered iready/txd/busy.
module axis_uart_tx #(
    parameter int CLOCK_DIV = 104
) (
    input  logic           clock,
    input  logic           reset,
    axis_uart_tx_if.slave  s_axis,
    output logic           txd,
    output logic           busy
);
    localparam int CW = (CLOCK_DIV > 2) ? $clog2(CLOCK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLOCK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, LAST} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [8:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          iready_q, iready_d;
    logic          accept;

    assign accept        = s_axis.ivalid && iready_q;
    assign s_axis.iready = iready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        iready_d = iready_q;
        case (state_q)
            IDLE, LAST: begin
                if (accept) begin
                    // Start bit sits in bit 0; shifting right fills with stop level.
                    shreg_d  = {s_axis.idata, 1'b0};
                    idx_d    = 4'd0;
                    cnt_d    = CNT_MAX;
                    state_d  = SHIFT;
                    txd_d    = 1'b0;
                    busy_d   = 1'b1;
                    iready_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    txd_d    = 1'b1;
                    busy_d   = 1'b0;
                    iready_d = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    shreg_d = {1'b1, shreg_q[8:1]};
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = CNT_MAX;
                    txd_d   = shreg_q[1];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
                // Open the handshake one cycle early so the next start bit abuts the stop bit.
                if (idx_q == 4'd9 && cnt_q == CNT_ONE) begin
                    state_d  = LAST;
                    iready_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                iready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 4'd0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            iready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            iready_q <= iready_d;
        end
    end

    // Data path only; no reset needed since txd is driven from its own register.
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end
endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx with CLOCK_DIV=4 and CLOCK_DIV=2 instances.
module tb_axis_uart_tx;
    logic       clock;
    logic       reset;
    logic       sel;
    logic       tb_valid;
    logic [7:0] tb_data;
    logic       txd4, busy4, txd2, busy2;
    logic       obs_txd, obs_busy, obs_ready, obs_valid;
    int         checks;
    int         failures;
    int         hs_cnt;

    axis_uart_tx_if if4 ();
    axis_uart_tx_if if2 ();

    assign if4.ivalid = tb_valid & ~sel;
    assign if4.idata  = tb_data;
    assign if2.ivalid = tb_valid & sel;
    assign if2.idata  = tb_data;

    axis_uart_tx #(.CLOCK_DIV(4)) dut4 (
        .clock (clock), .reset (reset), .s_axis (if4.slave), .txd (txd4), .busy (busy4));
    axis_uart_tx #(.CLOCK_DIV(2)) dut2 (
        .clock (clock), .reset (reset), .s_axis (if2.slave), .txd (txd2), .busy (busy2));

    assign obs_txd   = sel ? txd2 : txd4;
    assign obs_busy  = sel ? busy2 : busy4;
    assign obs_ready = sel ? if2.iready : if4.iready;
    assign obs_valid = sel ? if2.ivalid : if4.ivalid;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && obs_valid && obs_ready) hs_cnt <= hs_cnt + 1;
    end

    // Sends n (1 or 2) bytes starting just after an edge; checks every cycle of each frame.
    task automatic run_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input int n, input bit junk, input string tag);
        int         d;
        int         p;
        int         hs0;
        logic [9:0] fr;
        logic [2:0] exp_o;
        d = sel ? 2 : 4;
        p = 10 * d;
        tb_data  = b0;
        tb_valid = 1'b1;
        checks++;
        if (obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_before got=%b exp=1", tag, obs_ready);
        end
        hs0 = hs_cnt;
        @(posedge clock); #1;
        for (int f = 0; f < n; f++) begin
            fr       = (f == 0) ? {1'b1, b0, 1'b0} : {1'b1, b1, 1'b0};
            tb_data  = b1;
            tb_valid = (f < n - 1);
            for (int c = 0; c < p; c++) begin
                exp_o = {fr[c / d], 1'b1, (c == p - 1)};
                checks++;
                if ({obs_txd, obs_busy, obs_ready} !== exp_o) begin
                    failures++;
                    $display("FAIL %s_frame%0d cyc=%0d txd/busy/ready got=%b exp=%b",
                             tag, f, c, {obs_txd, obs_busy, obs_ready}, exp_o);
                end
                if (junk && c < p - 1) begin
                    tb_valid = 1'($urandom_range(0, 1));
                    tb_data  = 8'($urandom);
                end else if (junk) begin
                    tb_valid = (f < n - 1);
                    tb_data  = b1;
                end
                @(posedge clock); #1;
            end
        end
        tb_valid = 1'b0;
        checks++;
        if ({obs_txd, obs_busy, obs_ready} !== 3'b101) begin
            failures++;
            $display("FAIL %s_idle_after got=%b exp=101", tag, {obs_txd, obs_busy, obs_ready});
        end
        checks++;
        if (hs_cnt - hs0 !== n) begin
            failures++;
            $display("FAIL %s_handshakes got=%0d exp=%0d", tag, hs_cnt - hs0, n);
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({txd4, busy4, if4.iready, txd2, busy2, if2.iready} !== 6'b101101) begin
            failures++;
            $display("FAIL reset_state got=%b exp=101101",
                     {txd4, busy4, if4.iready, txd2, busy2, if2.iready});
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            checks++;
            if ({txd4, busy4, if4.iready, txd2, busy2, if2.iready} !== 6'b101101) begin
                failures++;
                $display("FAIL idle cyc=%0d got=%b exp=101101", i,
                         {txd4, busy4, if4.iready, txd2, busy2, if2.iready});
            end
        end
    endtask

    task automatic test_single();
        sel = 1'b0;
        run_stream(8'h55, 8'h00, 1, 1'b0, "single55");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_stream(8'h00, 8'hFF, 2, 1'b0, "b2b_00_ff");
    endtask

    task automatic test_ignore_when_busy();
        sel = 1'b0;
        run_stream(8'hC6, 8'h00, 1, 1'b1, "junk_c6");
        run_stream(8'h5A, 8'hE1, 2, 1'b1, "junk_5a_e1");
    endtask

    task automatic test_async_reset();
        sel      = 1'b0;
        tb_data  = 8'hA3;
        tb_valid = 1'b1;
        @(posedge clock); #1;
        tb_valid = 1'b0;
        repeat (17) @(posedge clock);
        #1;
        // A3 bit 3 is 0, so the line is low right before reset.
        checks++;
        if ({txd4, busy4, if4.iready} !== 3'b010) begin
            failures++;
            $display("FAIL rst_pre_bit3 got=%b exp=010", {txd4, busy4, if4.iready});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({txd4, busy4, if4.iready} !== 3'b101) begin
            failures++;
            $display("FAIL rst_async_immediate got=%b exp=101", {txd4, busy4, if4.iready});
        end
        @(posedge clock); #1;
        checks++;
        if ({txd4, busy4, if4.iready} !== 3'b101) begin
            failures++;
            $display("FAIL rst_held got=%b exp=101", {txd4, busy4, if4.iready});
        end
        reset = 1'b0;
        @(posedge clock); #1;
        run_stream(8'h3C, 8'h00, 1, 1'b0, "after_rst_3c");
    endtask

    task automatic test_div2();
        sel = 1'b1;
        run_stream(8'h80, 8'h01, 2, 1'b0, "div2_80_01");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        hs_cnt   = 0;
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        reset    = 1'b1;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_ignore_when_busy();
        test_async_reset();
        test_div2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
